// File: rtl/rf_wb_arbiter.sv
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Shares the register-file write port between the in-order
//                writeback (A) and a long-latency unit (B).  A has priority
//                unless B has been refused MAX_WAIT consecutive cycles.
//                Also keeps a 32-entry scoreboard of registers owed by B.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        A_VALID,
    input  logic [4:0]  A_WA,
    input  logic [31:0] A_WD,
    output logic        A_READY,
    input  logic        B_VALID,
    input  logic [4:0]  B_WA,
    input  logic [31:0] B_WD,
    output logic        B_READY,
    input  logic        ISSUE_VALID,
    input  logic [4:0]  ISSUE_RD,
    input  logic [4:0]  CHK_ADR1,
    input  logic [4:0]  CHK_ADR2,
    output logic        HAZARD1,
    output logic        HAZARD2,
    output logic [31:0] BUSY_MASK,
    output logic        RF_EN,
    output logic [4:0]  RF_WA,
    output logic [31:0] RF_WD
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt;
    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        force_b;
    logic        a_xfer;
    logic        b_xfer;
    logic [4:0]  win_wa;
    logic [31:0] win_wd;

    // Arbitration: B is forced ahead once it has waited long enough
    always_comb begin
        force_b = B_VALID && (wait_cnt >= MAX_WAIT_C);
        A_READY = !force_b;
        B_READY = !A_VALID || force_b;
        a_xfer  = A_VALID && A_READY;
        b_xfer  = B_VALID && B_READY;
        // a_xfer and b_xfer are mutually exclusive by construction
        win_wa  = b_xfer ? B_WA : A_WA;
        win_wd  = b_xfer ? B_WD : A_WD;
    end

    // Starvation counter: counts consecutive refusals of B, saturating
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= 4'd0;
        end else if (!B_VALID || b_xfer) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Registered write port; writes to x0 complete the handshake but never reach the file
    always_ff @(posedge CLK) begin
        if (RST) begin
            RF_EN <= 1'b0;
            RF_WA <= 5'd0;
            RF_WD <= 32'd0;
        end else if ((a_xfer || b_xfer) && (win_wa != 5'd0)) begin
            RF_EN <= 1'b1;
            RF_WA <= win_wa;
            RF_WD <= win_wd;
        end else begin
            RF_EN <= 1'b0;
        end
    end

    // Scoreboard next state: clear on B return, then set on issue so a newer op wins
    always_comb begin
        busy_next = busy;
        if (b_xfer) begin
            busy_next[B_WA] = 1'b0;
        end
        if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
            busy_next[ISSUE_RD] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard lookups are combinational on the current scoreboard
    always_comb begin
        HAZARD1   = busy[CHK_ADR1];
        HAZARD2   = busy[CHK_ADR2];
        BUSY_MASK = busy;
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter: directed scenarios
//                followed by randomized traffic, all compared against a
//                behavioural model of the arbitration and scoreboard rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        A_VALID;
    logic [4:0]  A_WA;
    logic [31:0] A_WD;
    logic        A_READY;
    logic        B_VALID;
    logic [4:0]  B_WA;
    logic [31:0] B_WD;
    logic        B_READY;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic [4:0]  CHK_ADR1;
    logic [4:0]  CHK_ADR2;
    logic        HAZARD1;
    logic        HAZARD2;
    logic [31:0] BUSY_MASK;
    logic        RF_EN;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD;

    rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_WA(A_WA), .A_WD(A_WD), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_WA(B_WA), .B_WD(B_WD), .B_READY(B_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .CHK_ADR1(CHK_ADR1), .CHK_ADR2(CHK_ADR2),
        .HAZARD1(HAZARD1), .HAZARD2(HAZARD2), .BUSY_MASK(BUSY_MASK),
        .RF_EN(RF_EN), .RF_WA(RF_WA), .RF_WD(RF_WD)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_busy [32];
    int          m_refused;
    bit          m_en;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    // One clock cycle: drive after the falling edge, check, then advance the model
    task automatic cycle(input logic rst_i,
                         input logic av, input logic [4:0] awa, input logic [31:0] awd,
                         input logic bv, input logic [4:0] bwa, input logic [31:0] bwd,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] c1, input logic [4:0] c2);
        bit e_force, e_ar, e_br, ax, bx;
        @(negedge CLK);
        RST = rst_i; A_VALID = av; A_WA = awa; A_WD = awd;
        B_VALID = bv; B_WA = bwa; B_WD = bwd;
        ISSUE_VALID = iv; ISSUE_RD = ird; CHK_ADR1 = c1; CHK_ADR2 = c2;
        #1;
        e_force = bv && (m_refused >= MAX_WAIT);
        e_ar    = !e_force;
        e_br    = !av || e_force;
        check("a_ready", 32'(A_READY), 32'(e_ar));
        check("b_ready", 32'(B_READY), 32'(e_br));
        check("busy_mask", BUSY_MASK, model_mask());
        check("hazard1", 32'(HAZARD1), 32'(m_busy[c1]));
        check("hazard2", 32'(HAZARD2), 32'(m_busy[c2]));
        check("rf_en", 32'(RF_EN), 32'(m_en));
        check("rf_wa", 32'(RF_WA), 32'(m_wa));
        check("rf_wd", RF_WD, m_wd);
        if (rst_i) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_refused = 0; m_en = 0; m_wa = '0; m_wd = '0;
        end else begin
            ax = av && e_ar;
            bx = bv && e_br;
            m_en = 0;
            if (bx && bwa != 0) begin m_en = 1; m_wa = bwa; m_wd = bwd; end
            else if (ax && awa != 0) begin m_en = 1; m_wa = awa; m_wd = awd; end
            if (bx) m_busy[bwa] = 0;
            if (iv && ird != 0) m_busy[ird] = 1;
            if (!bv || bx) m_refused = 0;
            else if (m_refused < MAX_WAIT) m_refused++;
        end
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, c1, c2);
    endtask

    initial begin
        m_refused = 0; m_en = 0; m_wa = '0; m_wd = '0;
        foreach (m_busy[i]) m_busy[i] = 0;
        RST = 1; A_VALID = 0; A_WA = 0; A_WD = 0; B_VALID = 0; B_WA = 0; B_WD = 0;
        ISSUE_VALID = 0; ISSUE_RD = 0; CHK_ADR1 = 0; CHK_ADR2 = 0;

        // Reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        check("reset_en", 32'(RF_EN), 32'd0);
        check("reset_mask", BUSY_MASK, 32'd0);

        // A only
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        check("aonly_en", 32'(RF_EN), 32'd1);
        check("aonly_wa", 32'(RF_WA), 32'd5);
        check("aonly_wd", RF_WD, 32'hDEADBEEF);
        idle(0, 0);
        check("aonly_en_drop", 32'(RF_EN), 32'd0);

        // Scoreboard round trip
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        cycle(0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 7);
        check("rt_mask_set", BUSY_MASK, 32'h80);
        check("rt_haz1", 32'(HAZARD1), 32'd1);
        idle(7, 0);
        check("rt_mask_clr", BUSY_MASK, 32'd0);
        check("rt_wa", 32'(RF_WA), 32'd7);
        check("rt_wd", RF_WD, 32'h1234);

        // Starvation: A and B both held high
        for (int i = 0; i < 7; i++)
            cycle(0, 1, 3, 32'hA000_0000 + i, 1, 4, 32'hB000_0000 + i, 0, 0, 0, 0);
        idle(0, 0);

        // x0 handling
        cycle(0, 1, 0, 32'h5555, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0);
        check("x0_en", 32'(RF_EN), 32'd0);
        check("x0_haz", 32'(HAZARD1), 32'd0);

        // Set/clear collision on register 9
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cycle(0, 0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0);
        idle(9, 0);
        check("coll_busy9", 32'(HAZARD1), 32'd1);

        // Reset mid-operation
        cycle(0, 0, 0, 0, 1, 9, 32'h1, 0, 0, 0, 0);
        for (int r = 8; r < 12; r++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'(r), 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 2, 32'h22, 1, 8, 32'h88, 0, 0, 0, 0);
        cycle(1, 1, 2, 32'h22, 1, 8, 32'h88, 0, 0, 0, 0);
        check("rst_mid_mask", BUSY_MASK, 32'h0000_0F00);
        for (int i = 0; i < 6; i++) cycle(0, 1, 2, 32'h22, 1, 8, 32'h88, 0, 0, 8, 9);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (enable, write address, write data; write lands on the falling clock edge) between two requesters: A, the in-order pipeline writeback, and B, a long-latency unit such as a multiply/divide or load return.
- Keeps a 32-entry scoreboard of destination registers still owed by B, so decode can stall on RAW hazards.
- Sits between the writeback stage, the long-latency unit and the register file.

Parameters:
- MAX_WAIT, 4, number of consecutive cycles B may be refused before it is forced ahead of A. Legal range is 0..15; 0 means B always has priority.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- A_VALID  in  1  pipeline writeback request
- A_WA  in  5  A destination register
- A_WD  in  32  A write data
- A_READY  out  1  A transfer accepted this cycle
- B_VALID  in  1  long-latency result request
- B_WA  in  5  B destination register
- B_WD  in  32  B write data
- B_READY  out  1  B transfer accepted this cycle
- ISSUE_VALID  in  1  long-latency op issued this cycle
- ISSUE_RD  in  5  its destination register
- CHK_ADR1  in  5  decode source-1 address
- CHK_ADR2  in  5  decode source-2 address
- HAZARD1  out  1  CHK_ADR1 is pending (combinational)
- HAZARD2  out  1  CHK_ADR2 is pending (combinational)
- BUSY_MASK  out  32  scoreboard bits; bit 0 is always 0
- RF_EN  out  1  register-file write enable (registered)
- RF_WA  out  5  register-file write address (registered)
- RF_WD  out  32  register-file write data (registered)

Behaviour:
- **Force condition:** force = B_VALID && (wait_cnt >= MAX_WAIT).
- **Ready outputs (combinational, independent of own VALID):**
  - A_READY = !force.
  - B_READY = !A_VALID || force.
  - Transfer on a port = VALID && READY on that port. At most one transfer per cycle.
- **Starvation counter wait_cnt** (4 bits, reset 0):
  - Clears when B_VALID == 0 or when B transfers.
  - Increments, saturating at MAX_WAIT, when B_VALID && !B_READY.
  - Two-state view:
    - NORMAL (wait_cnt < MAX_WAIT): A has priority.
    - FORCE_B (wait_cnt == MAX_WAIT && B_VALID): B is granted and A_READY = 0.
    - Return to NORMAL on the B transfer.
- **Write register** (latency 1: winner at rising edge n, RF_EN high during cycle n+1, register file writes at that cycle's falling edge):
  - On transfer with WA != 0: RF_EN <= 1, RF_WA/RF_WD <= winner's WA/WD.
  - On transfer with WA == 0: handshake completes (READY still asserted), RF_EN <= 0, RF_WA/RF_WD hold.
  - No transfer: RF_EN <= 0, RF_WA/RF_WD hold.
- **Scoreboard busy[31:0]:**
  - Set busy[ISSUE_RD] on ISSUE_VALID && ISSUE_RD != 0.
  - Clear busy[B_WA] on a B transfer.
  - Same cycle set and clear of the same register: set wins (a newer op owns the register).
  - Issue to x0 is ignored. B transfer to a non-busy register is legal; the clear is a no-op.
  - An A write to a busy register is not blocked and does not change the scoreboard. Decode must prevent this via HAZARD.
- **Hazard outputs:**
  - HAZARD1 = busy[CHK_ADR1]; HAZARD2 = busy[CHK_ADR2]; BUSY_MASK = busy.
  - A busy bit clears at the rising edge that captures B. The falling-edge write completes before the next rising edge, so a consumer released by HAZARD reads the new value. No extra hold cycle.
- **Reset** (synchronous, overrides everything including mid-transfer):
  - RF_EN = 0, RF_WA = 0, RF_WD = 0, busy = 0, wait_cnt = 0.
  - READY outputs follow their combinational equations from the reset state.
  - A B result presented during reset is not transferred; the long-latency unit must also be reset.

Test Plan:
- **A only:** A_VALID=1, A_WA=5, A_WD=0xDEADBEEF for 1 cycle → A_READY=1; next cycle RF_EN=1, RF_WA=5, RF_WD=0xDEADBEEF; following cycle RF_EN=0.
- **Scoreboard round trip:** ISSUE_VALID=1, ISSUE_RD=7 → BUSY_MASK=0x80, HAZARD1=1 with CHK_ADR1=7. Then B_VALID=1, B_WA=7, B_WD=0x1234, A idle → B_READY=1; next cycle BUSY_MASK=0, RF_WA=7, RF_WD=0x1234.
- **Starvation with MAX_WAIT=4:** A_VALID and B_VALID held high → B_READY=0 for 4 cycles; 5th cycle A_READY=0, B_READY=1, B written; wait_cnt returns to 0 and A regains priority.
- **x0 handling:** A_WA=0 transfer → A_READY=1, RF_EN stays 0. ISSUE_RD=0 → BUSY_MASK unchanged, HAZARD for CHK_ADR=0 is 0.
- **Set/clear collision:** busy[9]=1; same cycle B transfers B_WA=9 and ISSUE_RD=9 → busy[9] remains 1.
- **Reset mid-operation:** busy=0x0000_0F00, wait_cnt=3, RST=1 for 1 cycle → next cycle BUSY_MASK=0, RF_EN=0, RF_WA=0, RF_WD=0, counter restarts (B needs another 4 refusals before being forced).
